sipo_framer: RTL

Serial-to-parallel framer that feeds the SZE-bit data input of the downstream parallel holding register.
- Recovers frames of the form: start bit (0), SZE data bits LSB first, stop bit (1), from a single serial line.
- Presents each completed word with a one-cycle valid strobe, used as the downstream load enable.
- Line idle state and parallel-output reset value are all-ones, consistent with the downstream register reset value.

---
 rtl/sipo_framer_pkg.sv | 18 +
 rtl/sipo_framer_if.sv | 25 ++
 rtl/sipo_framer_sync_chain.sv | 25 ++
 rtl/sipo_framer.sv | 103 ++++++++++
 4 files changed

// File: rtl/sipo_framer_pkg.sv
// Shared types and constants for the serial-to-parallel framer.
package sipo_framer_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DATA      = 2'd1,
        STOP      = 2'd2,
        WAIT_HIGH = 2'd3
    } state_t;

    localparam logic IDLE_LVL = 1'b1;

    // Bit counter width: enough to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sipo_framer_if.sv
// Serial input controls and parallel word output of the framer.
interface sipo_framer_if #(
    parameter int unsigned SZE = 4
);
    import sipo_framer_pkg::*;

    logic           sample_en;
    logic           sin;
    logic           clr;
    logic [SZE-1:0] word;
    logic           word_valid;
    logic           frame_err;
    logic           busy;

    modport master (
        input  sample_en, sin, clr,
        output word, word_valid, frame_err, busy
    );

    modport slave (
        output sample_en, sin, clr,
        input  word, word_valid, frame_err, busy
    );

endinterface

// File: rtl/sipo_framer_sync_chain.sv
// Multi-flop synchroniser for an asynchronous level, resetting to the idle line level.
module sync_chain
    import sipo_framer_pkg::*;
#(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= {STAGES{IDLE_LVL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/sipo_framer.sv
// Recovers start/data(LSB first)/stop frames from a serial line and presents each word with a one-cycle strobe.
module sipo_framer
    import sipo_framer_pkg::*;
#(
    parameter int unsigned SZE         = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    sipo_framer_if.master      bus
);

    localparam int unsigned CW = cnt_width(SZE);

    logic           s;
    state_t         state, state_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic [SZE-1:0] shreg, shreg_nx;
    logic [SZE-1:0] word_q, word_nx;
    logic           wv_q, wv_nx;
    logic           fe_q, fe_nx;
    logic           busy_q;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.sin),
        .q     (s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            shreg  <= '1;
            word_q <= '1;
            wv_q   <= 1'b0;
            fe_q   <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            shreg  <= shreg_nx;
            word_q <= word_nx;
            wv_q   <= wv_nx;
            fe_q   <= fe_nx;
            busy_q <= (state_nx != IDLE);
        end
    end

    // Next-state logic; clr wins over sample_en, and nothing moves without sample_en.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        shreg_nx = shreg;
        word_nx  = word_q;
        wv_nx    = 1'b0;
        fe_nx    = 1'b0;

        if (bus.clr) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            shreg_nx = '1;
        end else if (bus.sample_en) begin
            unique case (state)
                IDLE: begin
                    if (!s) begin
                        state_nx = DATA;
                        cnt_nx   = '0;
                    end
                end
                DATA: begin
                    shreg_nx = {s, shreg[SZE-1:1]};
                    if (cnt == CW'(SZE - 1)) begin
                        state_nx = STOP;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (s) begin
                        word_nx  = shreg;
                        wv_nx    = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        fe_nx    = 1'b1;
                        state_nx = WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (s) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign bus.word       = word_q;
    assign bus.word_valid = wv_q;
    assign bus.frame_err  = fe_q;
    assign bus.busy       = busy_q;

endmodule
